noc_out_port: RTL and testbench
===============================

NOC_OUT_PORT -- requirements
Module: noc_out_port

Interface
REQ-001: Parameter DEPTH, default 4, sets the local flit FIFO entries (power of two, >=2).
REQ-002: Parameter CREDITS, default 4, sets the downstream input-buffer depth and the initial credit count (1..15).
REQ-003: clk  input  1  single clock; all state updates on the rising edge.
REQ-004: reset  input  1  asynchronous, active-high reset.
REQ-005: in_data_i  input  16  flit from the local crossbar or injector.
REQ-006: in_valid_i  input  1  in_data_i is valid this cycle.
REQ-007: in_ready_o  output  1  the FIFO can accept a flit this cycle.
REQ-008: data_o  output  16  flit to the neighbouring router's *_data_i port.
REQ-009: valid_o  output  1  data_o is valid; one flit per asserted cycle.
REQ-010: credit_i  input  1  one-cycle pulse from the neighbour's *_credit_o; returns one buffer slot.
REQ-011: credit_cnt_o  output  4  current available downstream credits.
REQ-012: credit_err_o  output  1  sticky flag: a credit arrived while the counter was already at CREDITS.

Function
REQ-013: The FIFO push SHALL occur on the edge where in_valid_i && in_ready_o; in_ready_o SHALL equal !full, combinationally.
REQ-014: On each edge, if the FIFO is non-empty and the effective credit count is nonzero, valid_o SHALL register 1, data_o SHALL register the FIFO head, and the head SHALL pop.
REQ-015: If that condition is false, valid_o SHALL register 0 and data_o SHALL hold its previous value.
REQ-016: Effective credit count = credit_cnt_o; a credit_i arriving in the same cycle SHALL NOT enable a send that cycle (no credit bypass).
REQ-017: Latency: a flit pushed at edge k into an empty FIFO with credits available SHALL appear on valid_o/data_o after edge k+1 (no FIFO bypass).
REQ-018: Counter update: send only -> -1; credit_i only -> +1; both -> unchanged; neither -> unchanged.
REQ-019: credit_i with credit_cnt_o==CREDITS and no send SHALL leave the counter at CREDITS and set credit_err_o until reset.
REQ-020: The counter SHALL never go below 0; a send SHALL be impossible at 0 credits.
REQ-021: Simultaneous push and pop SHALL both take effect; occupancy SHALL be unchanged.
REQ-022: FIFO pointers SHALL wrap modulo DEPTH; occupancy SHALL range 0..DEPTH.
REQ-023: Flit order SHALL be preserved end to end; no flit SHALL be dropped or duplicated.

Reset
REQ-024: While reset is high: valid_o=0, data_o=16'h0000, FIFO empty, credit_cnt_o=CREDITS, credit_err_o=0, in_ready_o=1.
REQ-025: Reset asserted mid-operation SHALL discard all buffered flits immediately, without waiting for a clock edge.
REQ-026: credit_i and in_valid_i SHALL be ignored while reset is high.

Configuration
REQ-027: Macro NOC_OUT_PORT_STATS_EN defined: adds output flit_count_o[15:0], reset to 0, incremented on each edge that registers valid_o=1, wrapping 16'hFFFF->0.
REQ-028: Macro undefined: flit_count_o and its counter SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-029: Reset, then push 16'hA001 with credit_i never pulsed -> valid_o=1, data_o=A001 one edge after the push; credit_cnt_o=3.
REQ-030: Push 6 flits (0x0001..0x0006) with no credit_i, CREDITS=4 -> exactly 4 sent in order, credit_cnt_o=0, 2 held; then pulse credit_i twice -> 0x0005 and 0x0006 sent.
REQ-031: Fill the FIFO (DEPTH=4) at credit_cnt_o=0 -> in_ready_o=0; a 5th flit on in_valid_i is not accepted; one credit_i pulse -> one flit sent, in_ready_o returns to 1.
REQ-032: credit_i in the same cycle as a send at credit_cnt_o=1 -> count stays 1, the next send proceeds the following edge.
REQ-033: credit_i at credit_cnt_o=CREDITS with an empty FIFO -> count stays 4, credit_err_o=1 until reset.
REQ-034: Assert reset asynchronously with 3 flits buffered -> valid_o=0, in_ready_o=1, credit_cnt_o=4 before the next edge; no stale flit emitted after release.

Source files
------------

// File: rtl/noc_out_port.sv
// Credit-based NoC output port: local flit FIFO feeding a registered link, gated by downstream credits.
// Define NOC_OUT_PORT_STATS_EN to add the flit_count_o sent-flit counter.
module noc_out_port #(
  parameter int DEPTH   = 4,
  parameter int CREDITS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] in_data_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  output logic [15:0] data_o,
  output logic        valid_o,
  input  logic        credit_i,
  output logic [3:0]  credit_cnt_o,
  output logic        credit_err_o
`ifdef NOC_OUT_PORT_STATS_EN
  ,
  output logic [15:0] flit_count_o
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
  localparam logic [3:0]    CREDITS_C = 4'(CREDITS);

  logic [15:0]   mem_q [DEPTH];
  logic [AW-1:0] wrPtr_q, wrPtr_d;
  logic [AW-1:0] rdPtr_q, rdPtr_d;
  logic [CW-1:0] count_q, count_d;
  logic [3:0]    creditCnt_q, creditCnt_d;
  logic          creditErr_q, creditErr_d;
  logic [15:0]   data_q, data_d;
  logic          valid_q, valid_d;
  logic          push;
  logic          send;
  logic          fifoEmpty;
  logic          fifoFull;

  assign fifoEmpty = (count_q == '0);
  assign fifoFull  = (count_q == DEPTH_C);

  assign in_ready_o = !fifoFull;
  assign push       = in_valid_i && in_ready_o;
  // Only the registered count gates a send; a credit arriving this cycle waits an edge.
  assign send       = !fifoEmpty && (creditCnt_q != 4'd0);

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (push) begin
      wrPtr_d = wrPtr_q + 1'b1;
    end
    if (send) begin
      rdPtr_d = rdPtr_q + 1'b1;
    end
    case ({push, send})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    creditCnt_d = creditCnt_q;
    creditErr_d = creditErr_q;
    if (send && !credit_i) begin
      creditCnt_d = creditCnt_q - 4'd1;
    end else if (credit_i && !send) begin
      // A credit with every downstream slot already free means the neighbour is miscounting.
      if (creditCnt_q == CREDITS_C) begin
        creditErr_d = 1'b1;
      end else begin
        creditCnt_d = creditCnt_q + 4'd1;
      end
    end
  end

  always_comb begin
    valid_d = send;
    data_d  = send ? mem_q[rdPtr_q] : data_q;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wrPtr_q] <= in_data_i;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrPtr_q     <= '0;
      rdPtr_q     <= '0;
      count_q     <= '0;
      creditCnt_q <= CREDITS_C;
      creditErr_q <= 1'b0;
      data_q      <= 16'h0000;
      valid_q     <= 1'b0;
    end else begin
      wrPtr_q     <= wrPtr_d;
      rdPtr_q     <= rdPtr_d;
      count_q     <= count_d;
      creditCnt_q <= creditCnt_d;
      creditErr_q <= creditErr_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
    end
  end

  assign data_o       = data_q;
  assign valid_o      = valid_q;
  assign credit_cnt_o = creditCnt_q;
  assign credit_err_o = creditErr_q;

`ifdef NOC_OUT_PORT_STATS_EN
  logic [15:0] flitCount_q, flitCount_d;

  assign flitCount_d = send ? flitCount_q + 16'd1 : flitCount_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flitCount_q <= 16'h0000;
    end else begin
      flitCount_q <= flitCount_d;
    end
  end

  assign flit_count_o = flitCount_q;
`endif

endmodule

// File: tb/tb_noc_out_port.sv
// Bench for noc_out_port: queue/credit reference model checked every cycle plus directed literal checks.
module tb_noc_out_port;

  localparam int DEPTH   = 4;
  localparam int CREDITS = 4;

  logic        clk;
  logic        reset;
  logic [15:0] inData;
  logic        inValid;
  logic        inReady;
  logic [15:0] dataOut;
  logic        validOut;
  logic        creditIn;
  logic [3:0]  creditCnt;
  logic        creditErr;
`ifdef NOC_OUT_PORT_STATS_EN
  logic [15:0] flitCount;
`endif

  int checks = 0;
  int errors = 0;

  logic [15:0] modelQ [$];
  int          modelCred;
  bit          modelErr;
  bit          modelValid;
  logic [15:0] modelData;
  logic [15:0] modelFlits;

  noc_out_port #(.DEPTH(DEPTH), .CREDITS(CREDITS)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_data_i    (inData),
    .in_valid_i   (inValid),
    .in_ready_o   (inReady),
    .data_o       (dataOut),
    .valid_o      (validOut),
    .credit_i     (creditIn),
    .credit_cnt_o (creditCnt),
    .credit_err_o (creditErr)
`ifdef NOC_OUT_PORT_STATS_EN
    ,
    .flit_count_o (flitCount)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, actual, expected);
    end
  endtask

  task automatic modelReset();
    modelQ.delete();
    modelCred  = CREDITS;
    modelErr   = 1'b0;
    modelValid = 1'b0;
    modelData  = 16'h0000;
    modelFlits = 16'h0000;
  endtask

  // One clock of stimulus; the model advances by the transfer rules once the edge has happened.
  task automatic applyStimulus(input logic v, input logic [15:0] d, input logic c);
    bit doSend;
    bit doPush;
    inValid  = v;
    inData   = d;
    creditIn = c;
    doSend = (modelQ.size() > 0) && (modelCred > 0);
    doPush = v && (modelQ.size() < DEPTH);
    @(posedge clk);
    if (!reset) begin
      if (doSend) begin
        modelData  = modelQ.pop_front();
        modelValid = 1'b1;
        modelFlits = modelFlits + 16'd1;
      end else begin
        modelValid = 1'b0;
      end
      if (doPush) modelQ.push_back(d);
      if (doSend && !c) begin
        modelCred--;
      end else if (c && !doSend) begin
        if (modelCred == CREDITS) modelErr = 1'b1;
        else modelCred++;
      end
    end
    #1;
    inValid  = 1'b0;
    inData   = 16'h0000;
    creditIn = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 16'h0000, 1'b0);
  endtask

  // Mid-cycle asynchronous reset with inputs hammered while it is held.
  task automatic doReset();
    modelReset();
    reset = 1'b1;
    #1;
    checkOutput("async_rst_valid", {15'd0, validOut}, 16'h0000);
    checkOutput("async_rst_ready", {15'd0, inReady}, 16'h0001);
    checkOutput("async_rst_cnt", {12'd0, creditCnt}, 16'h0004);
    checkOutput("async_rst_err", {15'd0, creditErr}, 16'h0000);
    checkOutput("async_rst_data", dataOut, 16'h0000);
    applyStimulus(1'b1, 16'hDEAD, 1'b1);
    applyStimulus(1'b1, 16'hBEEF, 1'b1);
    reset = 1'b0;
  endtask

  always @(negedge clk) begin
    checkOutput("cyc_valid", {15'd0, validOut}, {15'd0, modelValid});
    checkOutput("cyc_data", dataOut, modelData);
    checkOutput("cyc_ready", {15'd0, inReady}, {15'd0, (modelQ.size() < DEPTH)});
    checkOutput("cyc_credit", {12'd0, creditCnt}, 16'(modelCred));
    checkOutput("cyc_err", {15'd0, creditErr}, {15'd0, modelErr});
`ifdef NOC_OUT_PORT_STATS_EN
    checkOutput("cyc_flits", flitCount, modelFlits);
`endif
  end

  initial begin
    inValid  = 1'b0;
    inData   = 16'h0000;
    creditIn = 1'b0;
    reset    = 1'b1;
    modelReset();
    applyStimulus(1'b1, 16'hDEAD, 1'b1);
    applyStimulus(1'b1, 16'hDEAD, 1'b1);
    reset = 1'b0;
    #1;
    checkOutput("rst_valid", {15'd0, validOut}, 16'h0000);
    checkOutput("rst_cnt", {12'd0, creditCnt}, 16'h0004);
    checkOutput("rst_ready", {15'd0, inReady}, 16'h0001);

    $display("[TB] single flit latency");
    applyStimulus(1'b1, 16'hA001, 1'b0);
    checkOutput("no_bypass_valid", {15'd0, validOut}, 16'h0000);
    idle(1);
    checkOutput("lat_valid", {15'd0, validOut}, 16'h0001);
    checkOutput("lat_data", dataOut, 16'hA001);
    checkOutput("lat_cnt", {12'd0, creditCnt}, 16'h0003);
    applyStimulus(1'b0, 16'h0000, 1'b1);

    $display("[TB] credit starvation");
    for (int i = 1; i <= 6; i++) applyStimulus(1'b1, 16'(i), 1'b0);
    idle(1);
    checkOutput("starve_cnt", {12'd0, creditCnt}, 16'h0000);
    checkOutput("starve_valid", {15'd0, validOut}, 16'h0000);
    checkOutput("starve_hold", dataOut, 16'h0004);
    applyStimulus(1'b0, 16'h0000, 1'b1);
    idle(1);
    checkOutput("resume5_data", dataOut, 16'h0005);
    checkOutput("resume5_valid", {15'd0, validOut}, 16'h0001);
    applyStimulus(1'b0, 16'h0000, 1'b1);
    idle(1);
    checkOutput("resume6_data", dataOut, 16'h0006);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 16'h0000, 1'b1);

    $display("[TB] full FIFO backpressure");
    for (int i = 1; i <= 4; i++) applyStimulus(1'b1, 16'h0100 + 16'(i), 1'b0);
    idle(2);
    checkOutput("drain_cnt", {12'd0, creditCnt}, 16'h0000);
    for (int i = 1; i <= 4; i++) applyStimulus(1'b1, 16'h0200 + 16'(i), 1'b0);
    checkOutput("full_ready", {15'd0, inReady}, 16'h0000);
    applyStimulus(1'b1, 16'h02FF, 1'b0);
    checkOutput("full_reject_ready", {15'd0, inReady}, 16'h0000);
    applyStimulus(1'b0, 16'h0000, 1'b1);
    idle(1);
    checkOutput("full_pop_data", dataOut, 16'h0201);
    checkOutput("full_pop_ready", {15'd0, inReady}, 16'h0001);

    $display("[TB] async reset with three flits buffered");
    doReset();
    idle(3);
    checkOutput("post_rst_valid", {15'd0, validOut}, 16'h0000);

    $display("[TB] credit and send in the same cycle");
    applyStimulus(1'b1, 16'h0301, 1'b0);
    applyStimulus(1'b1, 16'h0302, 1'b0);
    applyStimulus(1'b1, 16'h0303, 1'b0);
    idle(1);
    checkOutput("same_pre_cnt", {12'd0, creditCnt}, 16'h0001);
    applyStimulus(1'b1, 16'h0304, 1'b0);
    applyStimulus(1'b1, 16'h0305, 1'b1);
    checkOutput("same_cnt", {12'd0, creditCnt}, 16'h0001);
    checkOutput("same_data", dataOut, 16'h0304);
    idle(1);
    checkOutput("same_next_valid", {15'd0, validOut}, 16'h0001);
    checkOutput("same_next_data", dataOut, 16'h0305);
    checkOutput("same_next_cnt", {12'd0, creditCnt}, 16'h0000);

    $display("[TB] credit overflow");
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 16'h0000, 1'b1);
    checkOutput("ovf_pre_err", {15'd0, creditErr}, 16'h0000);
    applyStimulus(1'b0, 16'h0000, 1'b1);
    checkOutput("ovf_err", {15'd0, creditErr}, 16'h0001);
    checkOutput("ovf_cnt", {12'd0, creditCnt}, 16'h0004);
    idle(3);
    checkOutput("ovf_sticky", {15'd0, creditErr}, 16'h0001);
    doReset();

    $display("[TB] mixed traffic");
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 2) == 0));
    end
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
